// File: rtl/lab4_sys_test_mem_responder.sv
// rtl/lab4_sys_test_mem_responder.sv - single-outstanding, fixed-latency 16B line memory responder
//
// Purpose: backing memory at the memory end of the 16B cache-to-memory stream.
//   Accepts one request at a time. Writes and inits update storage when the
//   request is accepted. The response is returned p_latency+1 cycles after accept.
//
// Ports:
//   clk             clock
//   reset           synchronous active-high reset
//   reqstream_msg   request  (msg_type, opaque, addr, len, data)
//   reqstream_val   request valid
//   reqstream_rdy   request ready
//   respstream_msg  response (msg_type, opaque, test, len, data)
//   respstream_val  response valid
//   respstream_rdy  response ready

package lab4_sys_test_mem_pkg;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

module lab4_sys_test_mem_responder
  import lab4_sys_test_mem_pkg::*;
#(
  parameter int p_num_lines = 256,
  parameter int p_latency   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  mem_req_16B_t  reqstream_msg,
  input  logic          reqstream_val,
  output logic          reqstream_rdy,
  output mem_resp_16B_t respstream_msg,
  output logic          respstream_val,
  input  logic          respstream_rdy
);

  localparam int IDX_W = $clog2(p_num_lines);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          post_reset;
  mem_resp_16B_t resp_q;
  mem_resp_16B_t resp_new;

  logic [127:0]     mem [p_num_lines];
  logic [IDX_W-1:0] idx;
  logic [3:0]       off;
  logic [4:0]       eff_len;
  int               off_i;
  int               len_i;
  logic [127:0]     line_rd;
  logic [127:0]     line_wr;
  logic [127:0]     rd_data;
  logic             is_read;
  logic             is_write;
  logic             req_fire;
  logic             rdy_c;
  logic             val_c;

  // Upper address bits alias onto the same line on purpose.
  logic unused_addr;
  assign unused_addr = ^reqstream_msg.addr[31:4+IDX_W];

  assign idx      = reqstream_msg.addr[4 +: IDX_W];
  assign off      = reqstream_msg.addr[3:0];
  assign eff_len  = (reqstream_msg.len == 4'd0) ? 5'd16 : {1'b0, reqstream_msg.len};
  assign off_i    = int'(off);
  assign len_i    = int'(eff_len);
  assign line_rd  = mem[idx];
  assign is_read  = (reqstream_msg.msg_type == 3'd0);
  assign is_write = (reqstream_msg.msg_type == 3'd1) || (reqstream_msg.msg_type == 3'd2);

  // Byte lane steering. Bytes that would land past byte 15 are dropped
  // rather than wrapped into the next line.
  always_comb begin
    line_wr = line_rd;
    rd_data = '0;
    for (int i = 0; i < 16; i++) begin
      if (i >= off_i && (i - off_i) < len_i)
        line_wr[i*8 +: 8] = reqstream_msg.data[(i - off_i)*8 +: 8];
      if (i < len_i && (i + off_i) < 16)
        rd_data[i*8 +: 8] = line_rd[(i + off_i)*8 +: 8];
    end
  end

  always_comb begin
    resp_new          = '0;
    resp_new.msg_type = reqstream_msg.msg_type;
    resp_new.opaque   = reqstream_msg.opaque;
    resp_new.test     = 2'b00;
    resp_new.len      = reqstream_msg.len;
    resp_new.data     = is_read ? rd_data : '0;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rdy_c      = 1'b0;
    val_c      = 1'b0;
    case (state)
      IDLE: begin
        // Also held off for one cycle after reset drops.
        rdy_c = !reset && !post_reset;
        if (reqstream_val && rdy_c) begin
          cnt_next   = 4'(p_latency);
          state_next = (p_latency == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = RESP;
        end
      end
      RESP: begin
        val_c = !reset;
        if (respstream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_fire       = reqstream_val && rdy_c;
  assign reqstream_rdy  = rdy_c;
  assign respstream_val = val_c;
  assign respstream_msg = val_c ? resp_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_q     <= '0;
      post_reset <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      post_reset <= 1'b0;
      if (req_fire) resp_q <= resp_new;
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (req_fire && is_write) mem[idx] <= line_wr;
  end

endmodule

// File: tb/tb_lab4_sys_test_mem_responder.sv
// tb/tb_lab4_sys_test_mem_responder.sv - self-checking bench for lab4_sys_test_mem_responder
module tb_lab4_sys_test_mem_responder;
  import lab4_sys_test_mem_pkg::*;

  localparam int P_LINES = 256;
  localparam int P_LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_16B_t  req_msg;
  logic          req_val, req_rdy;
  mem_resp_16B_t resp_msg;
  logic          resp_val, resp_rdy;

  mem_req_16B_t  z_req_msg;
  logic          z_req_val, z_req_rdy;
  mem_resp_16B_t z_resp_msg;
  logic          z_resp_val, z_resp_rdy;

  lab4_sys_test_mem_responder #(.p_num_lines(P_LINES), .p_latency(P_LAT)) dut (
    .clk(clk), .reset(reset),
    .reqstream_msg(req_msg), .reqstream_val(req_val), .reqstream_rdy(req_rdy),
    .respstream_msg(resp_msg), .respstream_val(resp_val), .respstream_rdy(resp_rdy)
  );

  lab4_sys_test_mem_responder #(.p_num_lines(P_LINES), .p_latency(0)) dut_z (
    .clk(clk), .reset(reset),
    .reqstream_msg(z_req_msg), .reqstream_val(z_req_val), .reqstream_rdy(z_req_rdy),
    .respstream_msg(z_resp_msg), .respstream_val(z_resp_val), .respstream_rdy(z_resp_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mm [P_LINES][16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd16) % P_LINES);
  endfunction

  function automatic logic [127:0] model_read(input logic [31:0] a, input logic [3:0] l);
    logic [127:0] r;
    int ln, o, n;
    r  = '0;
    ln = line_of(a);
    o  = int'(a % 32'd16);
    n  = (l == 4'd0) ? 16 : int'(l);
    for (int i = 0; i < n; i++)
      if (o + i < 16) r[i*8 +: 8] = mm[ln][o + i];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] l, input logic [127:0] d);
    int ln, o, n;
    ln = line_of(a);
    o  = int'(a % 32'd16);
    n  = (l == 4'd0) ? 16 : int'(l);
    for (int i = 0; i < n; i++)
      if (o + i < 16) mm[ln][o + i] = d[i*8 +: 8];
  endtask

  // One full transaction on the latency-P_LAT instance, checked against the model.
  task automatic xact(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [3:0] l, input logic [127:0] d, output logic [127:0] got);
    logic [127:0] exp_data;
    int w, lat;
    @(negedge clk);
    req_msg  = '{msg_type: t, opaque: op, addr: a, len: l, data: d};
    req_val  = 1'b1;
    resp_rdy = 1'b1;
    w = 0;
    while (!req_rdy && w < 20) begin @(negedge clk); w++; end
    chk("accept", req_rdy, 1'b1);
    exp_data = (t == 3'd0) ? model_read(a, l) : '0;
    if (t == 3'd1 || t == 3'd2) model_write(a, l, d);
    @(negedge clk);
    req_val = 1'b0;
    lat = 0;
    while (!resp_val && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", 128'(lat), 128'(P_LAT));
    chk("resp type", resp_msg.msg_type, t);
    chk("resp opaque", resp_msg.opaque, op);
    chk("resp test", resp_msg.test, 2'b00);
    chk("resp len", resp_msg.len, l);
    chk("resp data", resp_msg.data, exp_data);
    got = resp_msg.data;
    @(negedge clk);
    chk("rdy after resp", req_rdy, 1'b1);
    chk("val after resp", resp_val, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got, got2, held_data, exp;
    mem_resp_16B_t held;
    int w, n_acc, n_resp, last_acc, last_resp, seen;

    reset = 1'b1;
    req_val = 1'b0; resp_rdy = 1'b0; req_msg = '0;
    z_req_val = 1'b0; z_resp_rdy = 1'b0; z_req_msg = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset rdy", req_rdy, 1'b0);
    chk("reset val", resp_val, 1'b0);
    chk("reset msg", resp_msg, '0);
    reset = 1'b0;
    #1;
    chk("post-reset rdy", req_rdy, 1'b0);
    chk("post-reset val", resp_val, 1'b0);
    chk("post-reset msg", resp_msg, '0);
    @(negedge clk);
    chk("idle rdy", req_rdy, 1'b1);

    // 1. Write then read
    xact(3'd1, 8'h05, 32'h100, 4'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF, got);
    chk("t1 write data", got, '0);
    xact(3'd0, 8'h06, 32'h100, 4'd0, '0, got);
    chk("t1 read line", got, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // 2. Sub-line access
    xact(3'd2, 8'h10, 32'h200, 4'd0, {16{8'hAA}}, got);
    xact(3'd1, 8'h11, 32'h204, 4'd4, 128'hDEADBEEF, got);
    xact(3'd0, 8'h12, 32'h200, 4'd0, '0, got);
    chk("t2 full line", got, 128'hAAAAAAAA_AAAAAAAA_DEADBEEF_AAAAAAAA);
    xact(3'd0, 8'h13, 32'h206, 4'd2, '0, got);
    chk("t2 sub read", got, 128'hDEAD);

    // 3. Truncation at the line end
    xact(3'd2, 8'h20, 32'h300, 4'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100, got);
    xact(3'd2, 8'h21, 32'h310, 4'd0, 128'h1F1E1D1C_1B1A1918_17161514_13121110, got);
    xact(3'd1, 8'h22, 32'h30E, 4'd4, 128'h11223344, got);
    xact(3'd0, 8'h23, 32'h300, 4'd0, '0, got);
    chk("t3 line 0x300", got, 128'h33440D0C_0B0A0908_07060504_03020100);
    xact(3'd0, 8'h24, 32'h310, 4'd0, '0, got);
    chk("t3 line 0x310", got, 128'h1F1E1D1C_1B1A1918_17161514_13121110);

    // 4. Response backpressure
    @(negedge clk);
    req_msg  = '{msg_type: 3'd0, opaque: 8'h30, addr: 32'h100, len: 4'd0, data: '0};
    req_val  = 1'b1;
    resp_rdy = 1'b0;
    w = 0;
    while (!req_rdy && w < 20) begin @(negedge clk); w++; end
    chk("t4 accept", req_rdy, 1'b1);
    exp = model_read(32'h100, 4'd0);
    @(negedge clk);
    req_msg = '{msg_type: 3'd1, opaque: 8'h31, addr: 32'h100, len: 4'd0, data: '1};
    w = 0;
    while (!resp_val && w < 40) begin @(negedge clk); w++; end
    chk("t4 resp val", resp_val, 1'b1);
    held      = resp_msg;
    held_data = held.data;
    chk("t4 resp data", held_data, exp);
    chk("t4 resp opaque", held.opaque, 8'h30);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4 msg stable", resp_msg, held);
      chk("t4 val held", resp_val, 1'b1);
      chk("t4 req blocked", req_rdy, 1'b0);
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("t4 val drops", resp_val, 1'b0);
    chk("t4 rdy returns", req_rdy, 1'b1);
    xact(3'd0, 8'h32, 32'h100, 4'd0, '0, got);
    chk("t4 ignored write", got, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // 5. Zero latency, back-to-back reads with valid held high
    z_resp_rdy = 1'b1;
    n_acc = 0; n_resp = 0; last_acc = -10; last_resp = -10;
    for (int c = 0; c < 40 && n_resp < 6; c++) begin
      @(negedge clk);
      if (z_resp_val) begin
        chk("t5 opaque order", z_resp_msg.opaque, 8'(n_resp));
        chk("t5 resp after accept", 128'(c), 128'(last_acc + 1));
        if (n_resp > 0) chk("t5 resp spacing", 128'(c - last_resp), 128'd2);
        last_resp = c;
        n_resp++;
      end
      if (n_acc < 6) begin
        z_req_msg = '{msg_type: 3'd0, opaque: 8'(n_acc), addr: 32'(n_acc * 16), len: 4'd0, data: '0};
        z_req_val = 1'b1;
      end else begin
        z_req_val = 1'b0;
      end
      if (z_req_val && z_req_rdy) begin
        if (n_acc > 0) chk("t5 accept spacing", 128'(c - last_acc), 128'd2);
        last_acc = c;
        n_acc++;
      end
    end
    z_req_val = 1'b0;
    chk("t5 resp count", 128'(n_resp), 128'd6);

    // 6. Reset while a write is waiting for its response
    @(negedge clk);
    req_msg  = '{msg_type: 3'd1, opaque: 8'h40, addr: 32'h400, len: 4'd0,
                 data: 128'hC0FFEE00_12345678_9ABCDEF0_0BADF00D};
    req_val  = 1'b1;
    resp_rdy = 1'b1;
    w = 0;
    while (!req_rdy && w < 20) begin @(negedge clk); w++; end
    chk("t6 accept", req_rdy, 1'b1);
    model_write(32'h400, 4'd0, req_msg.data);
    @(negedge clk);
    req_val = 1'b0;
    reset   = 1'b1;
    #1;
    chk("t6 rdy in reset", req_rdy, 1'b0);
    chk("t6 val in reset", resp_val, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6 msg in reset", resp_msg, '0);
    reset = 1'b0;
    #1;
    chk("t6 rdy after reset", req_rdy, 1'b0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_val) seen++;
    end
    chk("t6 response discarded", 128'(seen), 128'd0);
    xact(3'd0, 8'h41, 32'h400, 4'd0, '0, got);
    chk("t6 write kept", got, 128'hC0FFEE00_12345678_9ABCDEF0_0BADF00D);
    xact(3'd0, 8'h42, 32'h400 + 32'(16 * P_LINES), 4'd0, '0, got2);
    chk("t6 alias", got2, got);

    // Randomized traffic over lines 0..7 with random upper address bits
    for (int ln = 0; ln < 8; ln++)
      xact(3'd2, 8'(ln), 32'(ln * 16), 4'd0, {$urandom, $urandom, $urandom, $urandom}, got);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) * 16) | 32'($urandom_range(0, 15));
      xact(3'($urandom_range(0, 3)), 8'($urandom), a, 4'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom}, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
